// File: rtl/sha256_round_ctrl.sv
// Round sequencer for the two-rounds-per-cycle SHA-256 compression datapath.
// Per block: load, 32 capture/commit pairs, final hash latch, done pulse.
module sha256_round_ctrl #(
   parameter int NUM_PAIRS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       first_block_i,
   input  logic       w_valid_i,
   output logic       w_ack_o,
   output logic [5:0] round_idx_o,
   output logic       core_rst_n_o,
   output logic       core_sel_o,
   output logic       hv_src_o,
   output logic       hv_load_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_CAPT,
      S_COMMIT,
      S_FINAL,
      S_DONE
   } state_e;

   localparam logic [4:0] LAST = 5'(NUM_PAIRS - 1);

   state_e     state_q;
   logic [4:0] p_q;
   logic       hv_src_q;
   logic       busy_q;
   logic       done_q;
   logic       sel_q;
   logic       load_q;
   logic       crst_n_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         p_q      <= '0;
         hv_src_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sel_q    <= 1'b0;
         load_q   <= 1'b0;
         crst_n_q <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         load_q   <= 1'b0;
         crst_n_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q  <= S_INIT;
                  hv_src_q <= ~first_block_i;
                  busy_q   <= 1'b1;
                  crst_n_q <= 1'b0;
               end
            end
            S_INIT: begin
               p_q     <= '0;
               state_q <= S_CAPT;
            end
            S_CAPT: begin
               if (w_valid_i) begin
                  state_q <= S_COMMIT;
                  sel_q   <= 1'b1;
               end
            end
            // sel stays high into FINAL so the hash latch follows the last commit
            S_COMMIT: begin
               if (p_q == LAST) begin
                  state_q <= S_FINAL;
               end else begin
                  p_q     <= p_q + 5'd1;
                  state_q <= S_CAPT;
                  sel_q   <= 1'b0;
               end
            end
            S_FINAL: begin
               state_q <= S_DONE;
               sel_q   <= 1'b0;
               done_q  <= 1'b1;
               load_q  <= 1'b1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               sel_q   <= 1'b0;
            end
         endcase
      end
   end

   assign w_ack_o      = (state_q == S_CAPT) & w_valid_i;
   assign round_idx_o  = {p_q, 1'b0};
   assign core_rst_n_o = rst & crst_n_q;
   assign core_sel_o   = sel_q;
   assign hv_src_o     = hv_src_q;
   assign hv_load_o    = load_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: drives a behavioural SHA-256 datapath and
// schedule from the controller outputs and checks timing and digests.
module tb_sha256_round_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       first_block;
   logic       w_valid;
   logic       w_ack;
   logic [5:0] round_idx;
   logic       core_rst_n;
   logic       core_sel;
   logic       hv_src;
   logic       hv_load;
   logic       busy;
   logic       done;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   sha256_round_ctrl #(.NUM_PAIRS(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .first_block_i(first_block),
      .w_valid_i    (w_valid),
      .w_ack_o      (w_ack),
      .round_idx_o  (round_idx),
      .core_rst_n_o (core_rst_n),
      .core_sel_o   (core_sel),
      .hv_src_o     (hv_src),
      .hv_load_o    (hv_load),
      .busy_o       (busy),
      .done_o       (done)
   );

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] DIG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_2B =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   localparam logic [511:0] BLK_ABC = {32'h61626380, {14{32'h0}}, 32'h00000018};
   localparam logic [511:0] BLK_2B1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
   };
   localparam logic [511:0] BLK_2B2 = {{15{32'h0}}, 32'h000001c0};

   logic [31:0]  wsch [64];
   logic [255:0] wr;
   logic [255:0] hout;
   logic [255:0] chain;
   logic [255:0] hsel;
   logic [31:0]  wc0;
   logic [31:0]  wc1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction

   function automatic logic [255:0] rnd(input logic [255:0] s,
                                        input logic [31:0] k,
                                        input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
             + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
             + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x,
                                         input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   task automatic load_msg(input logic [511:0] blk);
      logic [31:0] s0, s1;
      for (int i = 0; i < 16; i++) wsch[i] = blk[511 - 32*i -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(wsch[t-15], 7) ^ rotr(wsch[t-15], 18) ^ (wsch[t-15] >> 3);
         s1 = rotr(wsch[t-2], 17) ^ rotr(wsch[t-2], 19) ^ (wsch[t-2] >> 10);
         wsch[t] = s1 + wsch[t-7] + s0 + wsch[t-16];
      end
   endtask

   // Behavioural datapath: capture W on w_ack, two rounds per commit
   assign hsel = hv_src ? chain : IV;

   always @(posedge clk) begin
      if (!core_rst_n) begin
         wr <= hsel;
      end else if (core_sel) begin
         hout <= add8(hsel, wr);
         wr   <= rnd(rnd(wr, K[round_idx], wc0), K[round_idx | 6'd1], wc1);
      end else if (w_ack) begin
         wc0 <= wsch[round_idx];
         wc1 <= wsch[round_idx | 6'd1];
      end
      if (hv_load) chain <= hout;
   end

   task automatic idle_check(input int k);
      for (int i = 0; i < k; i++) begin
         start   = 1'b0;
         w_valid = 1'b0;
         @(negedge clk);
         nchk++;
         if ({busy, done} !== 2'b00) begin
            nerr++;
            $display("FAIL idle busy/done got %b want 00", {busy, done});
         end
         @(posedge clk); #1;
      end
   endtask

   // Phases: 1 INIT, 2 CAPT, 3 COMMIT, 4 FINAL, 5 DONE
   task automatic run_block(input bit fb, input bit stall_on,
                            input int sp0, input int sp1, input int rst_cyc,
                            input bit chk_dig, input logic [255:0] exp_dig,
                            input int exp_done);
      int ph, p, stl, acks;
      bit wv, fin;
      logic [5:0] exp_bus;
      ph = 1; p = 0; acks = 0; fin = 1'b0;
      stl = stall_on ? 3 : 0;
      start = 1'b1;
      first_block = fb;
      w_valid = !stall_on;
      @(negedge clk);
      nchk++;
      if ({busy, done} !== 2'b00) begin
         nerr++;
         $display("FAIL idle_before_start busy/done got %b want 00", {busy, done});
      end
      @(posedge clk); #1;
      for (int n = 1; n <= 200 && !fin; n++) begin
         start = (n == sp0) || (n == sp1);
         wv = (ph == 2) ? (stl == 0) : !stall_on;
         w_valid = wv;
         if (n == rst_cyc) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            start = 1'b0;
            @(negedge clk);
            nchk++;
            if ({busy, done, core_sel, round_idx} !== 9'b0) begin
               nerr++;
               $display("FAIL abort_clear busy/done/sel/idx got %b want 0",
                        {busy, done, core_sel, round_idx});
            end
            @(posedge clk); #1;
            return;
         end
         @(negedge clk);
         exp_bus = (ph == 1) ? 6'b100000 :
                   (ph == 2) ? {5'b10010, wv} :
                   (ph == 5) ? 6'b110110 : 6'b101100;
         nchk++;
         if ({busy, done, core_sel, core_rst_n, hv_load, w_ack} !== exp_bus) begin
            nerr++;
            $display("FAIL ctrl cycle %0d phase %0d got %b want %b", n, ph,
                     {busy, done, core_sel, core_rst_n, hv_load, w_ack}, exp_bus);
         end
         if (ph == 2 || ph == 3) begin
            nchk++;
            if (round_idx !== 6'(2 * p)) begin
               nerr++;
               $display("FAIL round_idx cycle %0d got %0d want %0d", n, round_idx, 2 * p);
            end
         end
         nchk++;
         if (hv_src !== ~fb) begin
            nerr++;
            $display("FAIL hv_src cycle %0d got %b want %b", n, hv_src, ~fb);
         end
         if (ph == 5) begin
            nchk++;
            if (n !== exp_done) begin
               nerr++;
               $display("FAIL done_cycle got %0d want %0d", n, exp_done);
            end
            nchk++;
            if (acks !== 32) begin
               nerr++;
               $display("FAIL w_ack_count got %0d want 32", acks);
            end
            if (chk_dig) begin
               nchk++;
               if (hout !== exp_dig) begin
                  nerr++;
                  $display("FAIL digest got %h want %h", hout, exp_dig);
               end
            end
            fin = 1'b1;
         end
         @(posedge clk); #1;
         case (ph)
            1: ph = 2;
            2: begin
               if (wv) begin
                  ph = 3;
                  acks++;
               end else begin
                  stl--;
               end
            end
            3: begin
               if (p == 31) begin
                  ph = 4;
               end else begin
                  p++;
                  ph = 2;
                  stl = (stall_on && (p == 15 || p == 31)) ? 3 : 0;
               end
            end
            4: ph = 5;
            default: ;
         endcase
      end
      start = 1'b0;
      if (!fin) begin
         nchk++;
         nerr++;
         $display("FAIL timeout no done within 200 cycles");
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b1;
      first_block = 1'b0;
      w_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      nchk++;
      if ({busy, done, core_sel, core_rst_n, hv_load, w_ack, hv_src, round_idx} !== 13'b0) begin
         nerr++;
         $display("FAIL reset_state got %b want 0",
                  {busy, done, core_sel, core_rst_n, hv_load, w_ack, hv_src, round_idx});
      end
      @(posedge clk); #1;
      rst = 1'b1;
      start = 1'b0;
      w_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      nchk++;
      if ({core_rst_n, busy, done} !== 3'b100) begin
         nerr++;
         $display("FAIL release_idle rstn/busy/done got %b want 100",
                  {core_rst_n, busy, done});
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_abc();
      idle_check(2);
      load_msg(BLK_ABC);
      run_block(1'b1, 1'b0, 0, 0, 0, 1'b1, DIG_ABC, 67);
   endtask

   task automatic test_two_block();
      load_msg(BLK_2B1);
      run_block(1'b1, 1'b0, 0, 0, 0, 1'b0, '0, 67);
      load_msg(BLK_2B2);
      run_block(1'b0, 1'b0, 0, 0, 0, 1'b1, DIG_2B, 67);
   endtask

   task automatic test_stall();
      idle_check(1);
      load_msg(BLK_ABC);
      run_block(1'b1, 1'b1, 0, 0, 0, 1'b1, DIG_ABC, 76);
   endtask

   task automatic test_back_to_back();
      idle_check(1);
      load_msg(BLK_ABC);
      run_block(1'b1, 1'b0, 10, 67, 0, 1'b1, DIG_ABC, 67);
      run_block(1'b1, 1'b0, 0, 0, 0, 1'b1, DIG_ABC, 67);
   endtask

   task automatic test_reset_mid();
      idle_check(1);
      load_msg(BLK_ABC);
      run_block(1'b1, 1'b0, 0, 0, 30, 1'b0, '0, 0);
      idle_check(3);
      run_block(1'b1, 1'b0, 0, 0, 0, 1'b1, DIG_ABC, 67);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      first_block = 1'b0;
      w_valid = 1'b0;
      test_reset();
      test_single_abc();
      test_two_block();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencing controller for the two-rounds-per-iteration pipelined SHA-256 compression datapath. For one 512-bit block it:
- loads the working registers from the block's initial hash value;
- issues 32 capture/commit double-round steps against a message-schedule W handshake;
- fires the final hash-latch cycle, then reports completion.

It also selects the initial-hash source, IV or chained previous digest, for multi-block messages. It sits between the message loader/schedule unit and the compression datapath.

## Interface
Parameters:
- NUM_PAIRS, 32, double-round steps per block (64 rounds / 2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  request to compress one block; sampled only in IDLE
- first_block  in  1  with start: 1 = initial hash is IV, 0 = chain from previous digest
- w_valid  in  1  schedule unit presents W[round_idx], W[round_idx+1]
- w_ack  out  1  W pair consumed this cycle
- round_idx  out  6  even round index 2p; datapath uses K/W at round_idx and round_idx|1
- core_rst_n  out  1  datapath load strobe (active-low): working regs <= h0..h7
- core_sel  out  1  datapath commit/latch enable
- hv_src  out  1  h0..h7 mux select: 0 = IV, 1 = chain register
- hv_load  out  1  chain register captures hash_val this cycle
- busy  out  1  block in progress
- done  out  1  one-cycle completion pulse; hash_val valid

## Operation
States and transitions:
- IDLE: wait for start; on start, latch hv_src <= ~first_block and go to INIT.
- INIT: core_rst_n=0 for one cycle; p <= 0; go to CAPT.
- CAPT: core_sel=0; round_idx=2p.
  - If w_valid: w_ack=1, go to COMMIT.
  - Otherwise stay (stall). Repeated pipeline captures are harmless.
- COMMIT: core_sel=1; round_idx held at 2p; w_ack=0.
  - If p==NUM_PAIRS-1, go to FINAL.
  - Else p <= p+1 and go to CAPT.
- FINAL: core_sel=1 for one cycle. The datapath latches h_out = h_i + final a..h; the garbage commit into the working regs is don't-care.
- DONE: done=1, hv_load=1 for one cycle; go to IDLE.

Output rules:
- busy=1 in every state except IDLE.
- hv_src is held constant from INIT through FINAL, because h0..h7 must stay stable while the final sum is latched.
- core_rst_n=0 in INIT, and also while rst=0. It is 1 otherwise.
- core_sel=1 only in COMMIT and FINAL. w_ack=1 only in CAPT with w_valid.
- W must be stable only during the CAPT cycle in which w_ack=1.
- p is a 5-bit counter, so round_idx = {p,1'b0} and never wraps within a block.

Reset (rst=0 at a clock edge) forces, from the next cycle:
- state=IDLE, p=0, round_idx=0, hv_src=0;
- busy, done, w_ack, core_sel, hv_load = 0;
- core_rst_n = 0 while rst is low.

Boundary conditions:
- start while busy: ignored, not queued.
- start in DONE: ignored. It is accepted only in IDLE on the following cycle.
- Reset mid-block: abort with no done. The next start is required to begin at INIT.
- w_valid deasserted in COMMIT or FINAL: no effect.

## Timing
- start accepted at edge E0. Then INIT is cycle 1, CAPT/COMMIT for pair p occupy cycles 2+2p and 3+2p, FINAL is cycle 66, DONE is cycle 67.
- Zero-stall latency from start to done is 67 cycles. Each stalled CAPT cycle adds exactly 1.
- hash_val is valid from cycle 67 and held until the next FINAL, or the next COMMIT of a later block.
- Back-to-back blocks: the next start is accepted at earliest in IDLE at cycle 68, giving 68 cycles per block.

## Test plan
- Single block "abc" (padded), first_block=1, w_valid tied 1:
  - done at cycle 67;
  - hash_val = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad;
  - exactly 32 w_ack pulses, round_idx stepping 0,2,…,62.
- Two-block 56-byte message "abcdbcdecdefdefg…nopq", blocks 1 and 2 with first_block=1 then 0:
  - hv_src=1 throughout block 2;
  - final hash_val = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- "abc" with w_valid low for 3 cycles before pairs 0, 15 and 31:
  - done at cycle 76, same digest;
  - core_sel stays 0 during the stalls and round_idx holds.
- start pulsed in cycles 10 and 67:
  - both ignored, a single done;
  - a start in cycle 68 begins a new block (INIT at 69).
- rst low for 1 cycle at cycle 30 of a block:
  - next cycle busy=0, core_sel=0, round_idx=0, no done;
  - a subsequent "abc" block produces the correct digest.
- Reset release: all outputs at reset values; core_rst_n=0 during reset, 1 in IDLE after release.
